// File: rtl/add_display_pkg.sv
// Shared types and constants for the hex accumulator / multiplexed display block.
package add_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_CLEAR,
    ST_RELEASE
  } state_t;

  localparam logic SEG_ON = 1'b1;
  localparam logic EN_ON  = 1'b1;

  // Active-high a..g, bit 6 = a, bit 0 = g
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-high a..g segment decoder.
module hex_to_seven_seg
  import add_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/add_display_scheduler.sv
// Hex accumulator with button-driven add/clear FSM and a time-multiplexed 7-segment scan.
// Optional button debounce enabled by defining ADD_DISPLAY_SCHEDULER_DEBOUNCE_EN.
module add_display_scheduler
  import add_display_pkg::*;
#(
  parameter int unsigned N_DIGITS        = 4,
  parameter int unsigned SCAN_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          operand,
  input  logic                add_btn,
  input  logic                clr_btn,
  output logic [6:0]          abcdefg,
  output logic [N_DIGITS-1:0] digit_en,
  output logic                carry,
  output logic                busy
);

  localparam int unsigned ACC_W = 4 * N_DIGITS;
  localparam int unsigned SCW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned IDXW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = {{(N_DIGITS-1){1'b0}}, 1'b1};

  if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("add_display_scheduler: SCAN_CYCLES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  // Bit 0 = add, bit 1 = clear
  logic [1:0] r_sync1, r_sync2;
  logic [1:0] w_btn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {clr_btn, add_btn};
      r_sync2 <= r_sync1;
    end
  end

`ifdef ADD_DISPLAY_SCHEDULER_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [DBW-1:0] r_db_cnt [2];
  logic [1:0]     r_db_lvl;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      r_db_lvl    <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (r_sync2[b] == r_db_lvl[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db_cnt[b] <= '0;
          r_db_lvl[b] <= r_sync2[b];
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign w_btn = r_db_lvl;
`else
  assign w_btn = r_sync2;
`endif

  state_t r_state, w_next;
  logic   w_do_add, w_do_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_btn[1])      w_next = ST_CLEAR;
        else if (w_btn[0]) w_next = ST_ADD;
      end
      ST_ADD:     w_next = ST_RELEASE;
      ST_CLEAR:   w_next = ST_RELEASE;
      ST_RELEASE: if (w_btn == 2'b00) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_do_add = 1'b0;
    w_do_clr = 1'b0;
    case (r_state)
      ST_ADD:   w_do_add = 1'b1;
      ST_CLEAR: w_do_clr = 1'b1;
      default:  ;
    endcase
  end

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;
  logic             r_carry, r_busy;

  assign w_sum = {1'b0, r_acc} + {{(ACC_W - 3){1'b0}}, operand};

  // busy tracks the registered state exactly, hence derived from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      if (w_do_clr) begin
        r_acc   <= '0;
        r_carry <= 1'b0;
      end else if (w_do_add) begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_carry <= r_carry | w_sum[ACC_W];
      end
    end
  end

  logic [SCW-1:0]  r_scan_cnt;
  logic [IDXW-1:0] r_scan_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == IDXW'(N_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  logic [3:0]          w_nibble;
  logic [6:0]          w_seg;
  logic [N_DIGITS-1:0] w_onehot;
  logic [6:0]          r_seg;
  logic [N_DIGITS-1:0] r_digit_en;

  assign w_nibble = r_acc[r_scan_idx * 4 +: 4];
  assign w_onehot = ONE_HOT0 << r_scan_idx;

  hex_to_seven_seg u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg      <= '0;
      r_digit_en <= '0;
    end else begin
      r_seg      <= SEG_ON ? w_seg : ~w_seg;
      r_digit_en <= EN_ON ? w_onehot : ~w_onehot;
    end
  end

  assign abcdefg  = r_seg;
  assign digit_en = r_digit_en;
  assign carry    = r_carry;
  assign busy     = r_busy;

endmodule

// File: tb/tb_add_display_scheduler.sv
// Directed self-checking bench for add_display_scheduler (N_DIGITS=4, SCAN_CYCLES=4).
module tb_add_display_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] operand;
  logic       add_btn, clr_btn;
  logic [6:0] abcdefg;
  logic [3:0] digit_en;
  logic       carry, busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

`ifdef ADD_DISPLAY_SCHEDULER_DEBOUNCE_EN
  localparam int unsigned HOLD   = 14;
  localparam int unsigned REL    = 14;
  localparam int unsigned ADD_AT = 11;
`else
  localparam int unsigned HOLD   = 4;
  localparam int unsigned REL    = 4;
  localparam int unsigned ADD_AT = 3;
`endif

  localparam logic [6:0] SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  add_display_scheduler #(
    .N_DIGITS        (4),
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .operand  (operand),
    .add_btn  (add_btn),
    .clr_btn  (clr_btn),
    .abcdefg  (abcdefg),
    .digit_en (digit_en),
    .carry    (carry),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic a, input logic c, input logic [3:0] op);
    operand = op;
    add_btn = a;
    clr_btn = c;
    tick(HOLD);
    add_btn = 1'b0;
    clr_btn = 1'b0;
    tick(REL);
  endtask

  // Waits (bounded) for each digit slot and checks its segment pattern
  task automatic check_display(input string tag, input logic [15:0] exp_acc);
    logic [3:0] want_en;
    logic [3:0] nib;
    for (int d = 0; d < 4; d++) begin
      want_en = 4'b0001 << d;
      nib     = exp_acc[4*d +: 4];
      for (int t = 0; t < 20 && digit_en !== want_en; t++) tick(1);
      chk($sformatf("%s_en%0d", tag, d), {28'd0, digit_en}, {28'd0, want_en});
      chk($sformatf("%s_seg%0d", tag, d), {25'd0, abcdefg}, {25'd0, SEG[nib]});
    end
  endtask

  initial begin
    reset   = 1'b1;
    operand = 4'h0;
    add_btn = 1'b0;
    clr_btn = 1'b0;
    tick(2);
    chk("rst_seg",   {25'd0, abcdefg}, 32'd0);
    chk("rst_en",    {28'd0, digit_en}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      chk($sformatf("scan_en_%0d", k), {28'd0, digit_en}, 32'd1 << ((k - 1) / 4));
      chk($sformatf("scan_seg_%0d", k), {25'd0, abcdefg}, 32'b1111110);
    end
    chk("post_rst_carry", {31'd0, carry}, 32'd0);
    chk("post_rst_busy",  {31'd0, busy}, 32'd0);

    // Long press of 9: one add, busy until release
    operand = 4'h9;
    add_btn = 1'b1;
    tick(ADD_AT + 1);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    tick(10);
    chk("hold_busy_late", {31'd0, busy}, 32'd1);
    add_btn = 1'b0;
    tick(REL);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    check_display("add9", 16'h0009);

`ifndef ADD_DISPLAY_SCHEDULER_DEBOUNCE_EN
    // Preload FFFE, then overflow by 3
    press(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 4368; i++) press(1'b1, 1'b0, 4'hF);
    press(1'b1, 1'b0, 4'hE);
    check_display("pre", 16'hFFFE);
    chk("pre_carry", {31'd0, carry}, 32'd0);
    press(1'b1, 1'b0, 4'h3);
    check_display("wrap", 16'h0001);
    chk("wrap_carry", {31'd0, carry}, 32'd1);
    press(1'b1, 1'b0, 4'h2);
    chk("sticky_carry", {31'd0, carry}, 32'd1);
    press(1'b0, 1'b1, 4'h0);
    check_display("clr", 16'h0000);
    chk("clr_carry", {31'd0, carry}, 32'd0);
`endif

    // Simultaneous add and clear: clear wins
    press(1'b0, 1'b1, 4'h0);
    press(1'b1, 1'b0, 4'h5);
    check_display("acc5", 16'h0005);
    press(1'b1, 1'b1, 4'h6);
    check_display("both", 16'h0000);
    chk("both_carry", {31'd0, carry}, 32'd0);

    // Async reset while in ADD
    press(1'b1, 1'b0, 4'h2);
    operand = 4'h7;
    add_btn = 1'b1;
    tick(ADD_AT);
    chk("inadd_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_seg",  {25'd0, abcdefg}, 32'd0);
    chk("arst_en",   {28'd0, digit_en}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    add_btn = 1'b0;
    tick(2);
    reset = 1'b0;
    check_display("arst", 16'h0000);

`ifdef ADD_DISPLAY_SCHEDULER_DEBOUNCE_EN
    // Bouncing button: short pulses rejected, long hold gives one add
    operand = 4'h1;
    for (int p = 0; p < 5; p++) begin
      add_btn = 1'b1;
      tick(3);
      add_btn = 1'b0;
      tick(3);
    end
    chk("bounce_busy", {31'd0, busy}, 32'd0);
    add_btn = 1'b1;
    tick(20);
    add_btn = 1'b0;
    tick(REL);
    check_display("deb", 16'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
